// File: rtl/scan_index_gen.sv
// Purpose  : time-multiplexed digit scanner feeding a 3-to-8 one-hot decoder, with frame-synchronous display buffer.
// Latency  : sel moves 1 cycle after a prescaler tick; loaded data shows at the next frame wrap (1 cycle when en=0).
// Backpres.: none; load is a strobe and the last load before a frame boundary wins.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   en              scan enable (en=0 clears the prescaler, freezes sel, applies pending data)
//   div_val         clock cycles per digit minus 1
//   digit_mask      bit i set = digit i displayed
//   data, load      display nibbles (nibble i = data[4i+3:4i]) and capture strobe
//   sel             registered scan index for the decoder
//   sel_valid       en & digit_mask[sel], gates the decoder output
//   nibble          active display nibble for the current sel
//   frame_done      1-cycle pulse after a wrapping step
//   pending         loaded data waiting for the next frame boundary
module scan_index_gen #(
   parameter int DIV_WIDTH = 16,
   parameter int NDIG      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [DIV_WIDTH-1:0] div_val,
   input  logic [7:0]           digit_mask,
   input  logic [31:0]          data,
   input  logic                 load,
   output logic [2:0]           sel,
   output logic                 sel_valid,
   output logic [3:0]           nibble,
   output logic                 frame_done,
   output logic                 pending
);

   logic [DIV_WIDTH-1:0] cnt;
   logic [31:0]          disp;
   logic [31:0]          pend_data;
   logic                 tick;
   logic                 found;
   logic                 wrap;
   logic                 apply;
   logic [2:0]           nxt;

   // Circular search for the next enabled digit, starting after sel.
   // The last candidate (k = NDIG) is sel itself, so a lone enabled digit
   // equal to sel is found and counts as a wrap.
   always_comb begin
      nxt   = sel;
      found = 1'b0;
      for (int k = 1; k <= NDIG; k++) begin
         if (!found && digit_mask[sel + 3'(k)]) begin
            nxt   = sel + 3'(k);
            found = 1'b1;
         end
      end
   end

   // >= rather than == so that lowering div_val below the running count
   // ticks immediately instead of waiting for the counter to roll over.
   assign tick  = en && (cnt >= div_val);
   assign wrap  = tick && found && (nxt <= sel);
   // Frame boundary for the display buffer: a wrap, or any idle cycle.
   assign apply = wrap || !en;

   assign sel_valid = en & digit_mask[sel];
   assign nibble    = disp[{sel, 2'b00} +: 4];

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         sel        <= '0;
         disp       <= '0;
         pend_data  <= '0;
         pending    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (!en || tick) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + DIV_WIDTH'(1);
         end

         if (tick) begin
            sel <= nxt;
         end

         frame_done <= wrap;

         if (load) begin
            pend_data <= data;
         end

         // A load landing on a boundary goes straight to the display so the
         // newest data is never held back a whole extra frame.
         if (load && apply) begin
            disp    <= data;
            pending <= 1'b0;
         end else if (load) begin
            pending <= 1'b1;
         end else if (pending && apply) begin
            disp    <= pend_data;
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_scan_index_gen.sv
module tb_scan_index_gen;

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] div_val;
   logic [7:0]  digit_mask;
   logic [31:0] data;
   logic        load;
   logic [2:0]  sel;
   logic        sel_valid;
   logic [3:0]  nibble;
   logic        frame_done;
   logic        pending;

   scan_index_gen #(.DIV_WIDTH(16), .NDIG(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .div_val    (div_val),
      .digit_mask (digit_mask),
      .data       (data),
      .load       (load),
      .sel        (sel),
      .sel_valid  (sel_valid),
      .nibble     (nibble),
      .frame_done (frame_done),
      .pending    (pending)
   );

   typedef struct {
      int         cyc;
      logic [9:0] v;     // {sel, nibble, sel_valid, frame_done, pending}
      string      name;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Expected state of the outputs during the current cycle window.
   task automatic expect_now(input string nm, input logic [2:0] s, input logic [3:0] n,
                             input logic sv, input logic fd, input logic pd);
      exp_t e;
      e.cyc  = cyc;
      e.v    = {s, n, sv, fd, pd};
      e.name = nm;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      en   = 1'b0;
      load = 1'b0;
      step();
      rst  = 1'b0;
   endtask

   // With en=0 a load bypasses straight into the display register.
   task automatic load_base();
      en   = 1'b0;
      load = 1'b1;
      data = 32'h7654_3210;
      step();
      load = 1'b0;
   endtask

   // Monitor: compares every queued expectation that falls due this cycle.
   always @(negedge clk) begin
      exp_t       e;
      logic [9:0] act;
      act = {sel, nibble, sel_valid, frame_done, pending};
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         total++;
         if (e.cyc != cyc) begin
            bad++;
            $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d", e.name, e.cyc, cyc);
         end else if (act !== e.v) begin
            bad++;
            $display("FAIL %s cyc=%0d: got sel=%0d nib=%h sv=%b fd=%b pend=%b, want sel=%0d nib=%h sv=%b fd=%b pend=%b",
                     e.name, cyc, act[9:7], act[6:3], act[2], act[1], act[0],
                     e.v[9:7], e.v[6:3], e.v[2], e.v[1], e.v[0]);
         end
      end
   end

   initial begin
      logic [2:0] s;
      logic [3:0] n;
      logic [2:0] seq3 [3];
      seq3[0] = 3'd0; seq3[1] = 3'd2; seq3[2] = 3'd5;

      rst = 1'b1; en = 1'b0; div_val = 16'd3; digit_mask = 8'hFF;
      data = 32'h0; load = 1'b0;
      step();
      step();
      rst = 1'b0;
      expect_now("reset", 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);

      // 1. Basic scan, div_val=3, all digits.
      load_base();
      en = 1'b1; div_val = 16'd3; digit_mask = 8'hFF;
      for (int w = 0; w < 37; w++) begin
         s = 3'((w / 4) % 8);
         expect_now("basic", s, {1'b0, s}, 1'b1, (w == 32), 1'b0);
         step();
      end

      // 2. Mask skip 0x25 at div_val=0, then mask cleared while sel=2.
      do_reset();
      load_base();
      en = 1'b1; div_val = 16'd0;
      for (int w = 0; w < 16; w++) begin
         digit_mask = (w < 10) ? 8'h25 : 8'h00;
         s = (w < 10) ? seq3[w % 3] : 3'd2;
         expect_now("mask", s, {1'b0, s}, (w < 10), (w < 10 && w > 0 && w % 3 == 0), 1'b0);
         step();
      end

      // 3. Tear-free update: load at sel=3, applied at the wrap.
      do_reset();
      load_base();
      en = 1'b1; div_val = 16'd0; digit_mask = 8'hFF;
      for (int w = 0; w < 11; w++) begin
         load = (w == 3);
         data = 32'hAAAA_AAAA;
         s = 3'(w % 8);
         n = (w >= 8) ? 4'hA : {1'b0, s};
         expect_now("tearfree", s, n, 1'b1, (w == 8), (w >= 4 && w <= 7));
         step();
      end
      load = 1'b0;

      // 4. Load colliding with the wrapping tick bypasses the pending buffer.
      do_reset();
      load_base();
      en = 1'b1; div_val = 16'd0; digit_mask = 8'hFF;
      for (int w = 0; w < 10; w++) begin
         load = (w == 1 || w == 7);
         data = (w == 7) ? 32'h2222_2222 : 32'h1111_1111;
         s = 3'(w % 8);
         n = (w >= 8) ? 4'h2 : {1'b0, s};
         expect_now("collide", s, n, 1'b1, (w == 8), (w >= 2 && w <= 7));
         step();
      end
      load = 1'b0;

      // 5a. Single digit 3: first tick moves there, later ticks wrap in place.
      do_reset();
      load_base();
      en = 1'b1; div_val = 16'd2; digit_mask = 8'h08;
      for (int w = 0; w < 11; w++) begin
         s = (w >= 3) ? 3'd3 : 3'd0;
         expect_now("single", s, {1'b0, s}, (w >= 3), (w >= 6 && w % 3 == 0), 1'b0);
         step();
      end

      // 5b. div_val lowered from 100 to 5 while cnt=50 ticks at once.
      do_reset();
      load_base();
      en = 1'b1; digit_mask = 8'h08;
      for (int w = 0; w < 59; w++) begin
         div_val = (w < 50) ? 16'd100 : 16'd5;
         s = (w >= 51) ? 3'd3 : 3'd0;
         expect_now("divchg", s, {1'b0, s}, (w >= 51), (w == 57), 1'b0);
         step();
      end

      // 6. Reset while sel=6, pending=1, cnt=2; scan restarts with a full period.
      do_reset();
      load_base();
      en = 1'b1; div_val = 16'd3; digit_mask = 8'hFF;
      for (int w = 0; w < 36; w++) begin
         load = (w == 25);
         data = 32'hAAAA_AAAA;
         rst  = (w == 26);
         if (w <= 26) begin
            s = 3'((w / 4) % 8);
            expect_now("midrst", s, {1'b0, s}, 1'b1, 1'b0, (w == 26));
         end else begin
            s = 3'((w - 27) / 4);
            expect_now("midrst", s, 4'h0, 1'b1, 1'b0, 1'b0);
         end
         step();
      end
      rst = 1'b0; load = 1'b0;

      // 7. Pending data applied when scanning is disabled.
      do_reset();
      load_base();
      div_val = 16'd100; digit_mask = 8'hFF;
      for (int w = 0; w < 5; w++) begin
         en   = (w < 2);
         load = (w == 0);
         data = 32'hFEDC_BA9F;
         n = (w >= 3) ? 4'hF : 4'h0;
         expect_now("idleapply", 3'd0, n, (w < 2), 1'b0, (w == 1 || w == 2));
         step();
      end
      load = 1'b0;

      step();
      step();
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/scan_index_gen.md
Name: scan_index_gen

Overview:
- Time-multiplexed digit scanner that sits directly upstream of the 3-to-8 one-hot decoder.
- Produces the 3-bit scan index that drives the decoder's `in`, the 4-bit nibble for the currently selected digit, and a gate qualifier.
- Steps through up to 8 digits at a programmable rate and skips masked-off digits.
- Double-buffers display data so that updates only take effect on a frame boundary, which prevents tearing.

Parameters:
- DIV_WIDTH, 16: width of the prescaler counter and of `div_val`.
- NDIG, 8: number of digits. Fixed at 8 to match the 3-bit index; not to be overridden.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  scan enable.
- div_val  input  DIV_WIDTH  number of clock cycles per digit, minus 1.
- digit_mask  input  8  bit i=1 means digit i is displayed.
- data  input  32  nibble i = data[4i+3:4i].
- load  input  1  1-cycle strobe that captures `data` into the pending buffer.
- sel  output  3  scan index; drives decoder `in`. Registered.
- sel_valid  output  1  equals en & digit_mask[sel]. Combinational; gates the decoder output.
- nibble  output  4  disp[4*sel+3:4*sel], where disp is the active display register.
- frame_done  output  1  1-cycle pulse when the scan wraps.
- pending  output  1  1 while loaded data is waiting to be applied.

Behaviour:
Reset (rst=1 at a clk edge):
- cnt=0, sel=0, disp=0, pend_data=0, pending=0, frame_done=0.
- Takes priority over every other input, including in mid-frame or mid-count.

Prescaler:
- en=0: cnt is held at 0 and sel holds its value.
- en=1: tick = (cnt >= div_val).
  - On tick, cnt<=0; otherwise cnt<=cnt+1.
  - The >= comparison means that lowering div_val mid-count ticks on the next cycle.
- div_val=0: tick every cycle.

Index advance on tick:
- next = first index j in circular order sel+1, sel+2, …, sel+8 (mod 8) with digit_mask[j]=1.
- sel<=next.
- Single set mask bit equal to sel: sel stays and the step counts as a wrap.
- digit_mask=0: sel is unchanged, no wrap, no frame_done.
- wrap = (next <= sel) with a nonzero mask.
- frame_done<=1 for exactly one cycle on a wrapping tick; 0 otherwise.

Buffering:
- load=1: pend_data<=data, pending<=1. A later load overwrites an earlier one; last wins.
- Apply:
  - Condition: a wrapping tick, or en=0.
  - Action: disp<=pend_data, pending<=0.
- load and apply in the same cycle: disp<=data directly (bypass), pending<=0.
- No apply occurs while pending=0.

Outputs:
- nibble and sel_valid are combinational from the registered sel and disp, plus the live en and digit_mask.
- A mask change takes effect on sel_valid immediately and on the index order at the next tick.

Latency:
- sel changes 1 cycle after the tick condition.
- Loaded data is visible on nibble at the first frame wrap after the load, or 1 cycle after the load if en=0.

Test Plan:
1. Basic scan:
   - Stimulus: rst 2 cycles, then en=1, div_val=3, mask=FF, load data=0x76543210 with en=0 first.
   - Response: sel steps 0,1,…,7,0 every 4 cycles; nibble==sel; sel_valid=1; frame_done pulses once per 32 cycles, in the cycle sel goes 7→0.
2. Mask skip:
   - Stimulus: mask=0x25, div_val=0.
   - Response: sel sequence 0,2,5,0,2,5; frame_done on each 5→0; sel_valid stays 1.
   - Then set mask=0x00: sel frozen, sel_valid=0, frame_done never asserts.
3. Tear-free update:
   - Stimulus: while scanning at sel=3, load data=0xAAAAAAAA.
   - Response: pending=1; nibble keeps the old values for sel 4–7; at the wrap to 0, nibble=0xA and pending=0.
4. Load/wrap collision:
   - Stimulus: load 0x11111111 earlier, then load 0x22222222 in the same cycle as the wrapping tick.
   - Response: disp=0x22222222, pending=0, nibble=2 on the next cycle.
5. Single digit + div change:
   - Stimulus: mask=0x08 with sel initially 0.
   - Response: the first tick moves sel to 3; each following tick keeps sel=3 and pulses frame_done.
   - Lower div_val from 100 to 5 when cnt=50: a tick occurs on the next cycle.
6. Reset mid-operation:
   - Stimulus: assert rst while sel=6, pending=1, cnt>0.
   - Response: next cycle sel=0, nibble=0, pending=0, frame_done=0; scan restarts from 0 with a full div_val+1 period.
